// File: rtl/uart_pkg.sv
// Shared types and constants for the UART controller: parity modes, FSM
// state encodings and the oversampling geometry.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int TICK_W     = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // The reserved encoding 3 behaves exactly like "no parity".
  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic parity_bit(input parity_e mode, input logic xor_data);
    return (mode == PAR_ODD) ? ~xor_data : xor_data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy output; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level already
  // define which entries are meaningful, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: shared 16x baud tick, FIFO-buffered TX and RX paths with
// runtime parity/stop selection and per-byte error flags.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DVSR_W     = 11,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DVSR_W-1:0]    dvsr,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 tx_busy,
  output logic [LVL_W-1:0]     tx_level,
  output logic [LVL_W-1:0]     rx_level
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP2_LAST = TICK_W'(2 * OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] MID_TICK   = TICK_W'(MID_SAMPLE);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);

  // ---------------- baud generator ----------------
  logic [DVSR_W-1:0] cnt_q, cnt_d, dvsr_q;
  logic              tick;

  assign tick  = (cnt_q == dvsr_q);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // The divisor is captured only at the wrap so a change never truncates a period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvsr_q <= dvsr;
    end else begin
      cnt_q <= cnt_d;
      if (tick) dvsr_q <= dvsr;
    end
  end

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_fifo_data, tx_shift_q;
  logic                 tx_full, tx_empty, tx_pop, tx_stop_last;
  tx_state_e            tx_state_q;
  logic [TICK_W-1:0]    tx_tick_q;
  logic [BIT_W-1:0]     tx_bit_q;
  parity_e              tx_par_q;
  logic                 tx_pbit_q, tx_stop2_q, tx_q;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid && tx_ready),
    .wdata_i (tx_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_fifo_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  assign tx_stop_last = (tx_tick_q == (tx_stop2_q ? STOP2_LAST : BIT_LAST));
  // Loading only on a tick aligns the start bit to the tick grid, so every
  // bit lasts exactly 16 tick periods and chained frames have no gap.
  assign tx_pop   = tick && !tx_empty &&
                    ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_stop_last));
  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state_q != TX_IDLE) || !tx_empty;
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= PAR_NONE;
      tx_pbit_q  <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_START: if (tick) begin
          if (tx_tick_q == BIT_LAST) begin
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
          end else tx_tick_q <= tx_tick_q + 1'b1;
        end
        TX_DATA: if (tick) begin
          if (tx_tick_q == BIT_LAST) begin
            tx_tick_q <= '0;
            if (tx_bit_q == DATA_LAST) begin
              tx_state_q <= (tx_par_q != PAR_NONE) ? TX_PARITY : TX_STOP;
              tx_q       <= (tx_par_q != PAR_NONE) ? tx_pbit_q : 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end else tx_tick_q <= tx_tick_q + 1'b1;
        end
        TX_PARITY: if (tick) begin
          if (tx_tick_q == BIT_LAST) begin
            tx_tick_q  <= '0;
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
          end else tx_tick_q <= tx_tick_q + 1'b1;
        end
        TX_STOP: if (tick) begin
          if (tx_stop_last) begin
            tx_tick_q  <= '0;
            tx_state_q <= TX_IDLE;
          end else tx_tick_q <= tx_tick_q + 1'b1;
        end
        default: ;
      endcase
      // A load overrides the stop-to-idle transition for back-to-back frames.
      if (tx_pop) begin
        tx_shift_q <= tx_fifo_data;
        tx_par_q   <= decode_parity(cfg_parity);
        tx_pbit_q  <= parity_bit(decode_parity(cfg_parity), ^tx_fifo_data);
        tx_stop2_q <= cfg_stop2;
        tx_tick_q  <= '0;
        tx_state_q <= TX_START;
        tx_q       <= 1'b0;
      end
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]             rx_sync_q;
  logic                   rx_s, rx_push, rx_pop, rx_full, rx_empty, rx_perr;
  rx_state_e              rx_state_q;
  logic [TICK_W-1:0]      rx_tick_q;
  logic [BIT_W-1:0]       rx_bit_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  parity_e                rx_par_q;
  logic                   rx_pbit_q, rx_overrun_q;
  logic [DATA_BITS+1:0]   rx_head;

  assign rx_s    = rx_sync_q[1];
  assign rx_push = (rx_state_q == RX_STOP) && tick && (rx_tick_q == BIT_LAST);
  assign rx_pop  = rx_valid && rx_ready;
  assign rx_perr = (rx_par_q != PAR_NONE) &&
                   (rx_pbit_q != parity_bit(rx_par_q, ^rx_shift_q));

  uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .wdata_i ({~rx_s, rx_perr, rx_shift_q}),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  // Outputs read as zero while empty so nothing stale leaks out after reset.
  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_empty ? '0 : rx_head[DATA_BITS-1:0];
  assign rx_parity_err = !rx_empty && rx_head[DATA_BITS];
  assign rx_frame_err  = !rx_empty && rx_head[DATA_BITS+1];
  assign rx_overrun    = rx_overrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_q    <= 2'b11;
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= PAR_NONE;
      rx_pbit_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[0], rx};
      rx_overrun_q <= rx_push && rx_full && !rx_pop;
      case (rx_state_q)
        RX_IDLE: if (!rx_s) begin
          rx_tick_q  <= '0;
          rx_par_q   <= decode_parity(cfg_parity);
          rx_state_q <= RX_START;
        end
        RX_START: if (tick) begin
          if (rx_tick_q == MID_TICK) begin
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else rx_tick_q <= rx_tick_q + 1'b1;
        end
        RX_DATA: if (tick) begin
          if (rx_tick_q == BIT_LAST) begin
            rx_tick_q  <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == DATA_LAST)
              rx_state_q <= (rx_par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
              rx_bit_q <= rx_bit_q + 1'b1;
          end else rx_tick_q <= rx_tick_q + 1'b1;
        end
        RX_PARITY: if (tick) begin
          if (rx_tick_q == BIT_LAST) begin
            rx_tick_q  <= '0;
            rx_pbit_q  <= rx_s;
            rx_state_q <= RX_STOP;
          end else rx_tick_q <= rx_tick_q + 1'b1;
        end
        RX_STOP: if (tick) begin
          if (rx_tick_q == BIT_LAST) begin
            rx_tick_q  <= '0;
            rx_state_q <= RX_IDLE;
          end else rx_tick_q <= rx_tick_q + 1'b1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl at dvsr=3 (one bit = 64 clocks): loopback
// framing, externally driven error frames, FIFO limits and reset abort.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] dvsr;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        rx, tx;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_parity_err, rx_frame_err, rx_overrun, tx_busy;
  logic [4:0]  tx_level, rx_level;

  logic loop_en, rx_drv;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovr_cnt  = 0;

  assign rx = loop_en ? tx : rx_drv;

  uart_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dvsr          (dvsr),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx            (rx),
    .tx            (tx),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .tx_busy       (tx_busy),
    .tx_level      (tx_level),
    .rx_level      (rx_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Returns cycle counts relative to the first low sample of tx.
  task automatic measure_frame(output int low_len, output int frame_len, output logic par_s);
    int n = 0;
    int idx = 0;
    low_len = -1;
    par_s   = 1'bx;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", tx, 1'b0);
    while (tx_busy && idx < 20000) begin
      if (low_len < 0 && tx == 1'b1) low_len = idx;
      if (idx == 608) par_s = tx;
      @(negedge clk);
      idx++;
    end
    frame_len = idx;
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    int n = 0;
    while (!rx_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"},  rx_data, d);
    check({tag, "_perr"},  rx_parity_err, pe);
    check({tag, "_ferr"},  rx_frame_err, fe);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Drives one frame on rx; a bad stop bit is held low for 40 clocks only.
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop_ok);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (64) @(negedge clk);
    end
    if (has_par) begin
      rx_drv = pbit;
      repeat (64) @(negedge clk);
    end
    if (!stop_ok) begin
      rx_drv = 1'b0;
      repeat (40) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    int   low_len, frame_len, k, n, t0, ovr_base;
    logic par_s;

    rst_n = 1'b0; dvsr = 11'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    loop_en = 1'b1; rx_drv = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_tx",       tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_busy",  tx_busy, 1'b0);
    check("rst_tx_level", tx_level, 5'd0);
    check("rst_rx_level", rx_level, 5'd0);
    check("rst_overrun",  rx_overrun, 1'b0);
    check("rst_perr",     rx_parity_err, 1'b0);
    check("rst_ferr",     rx_frame_err, 1'b0);
    check("rst_rx_data",  rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 8N1, 0xA5.
    push(8'hA5);
    measure_frame(low_len, frame_len, par_s);
    check("a5_start_len", low_len, 64);
    check("a5_frame_len", frame_len, 640);
    expect_rx("a5", 8'hA5, 1'b0, 1'b0);

    // Loopback even parity, two stop bits, 0x07 (three ones -> parity bit 1).
    cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    push(8'h07);
    measure_frame(low_len, frame_len, par_s);
    check("p07_start_len", low_len, 64);
    check("p07_parity_bit", par_s, 1'b1);
    check("p07_frame_len", frame_len, 768);
    expect_rx("p07", 8'h07, 1'b0, 1'b0);
    cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (20) @(negedge clk);

    // External odd-parity frames: wrong parity on 0x55, zero stop on 0x3C.
    loop_en = 1'b0; cfg_parity = 2'd2;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    check("err_level", rx_level, 5'd2);
    expect_rx("e55", 8'h55, 1'b1, 1'b0);
    expect_rx("e3c", 8'h3C, 1'b0, 1'b1);
    check("err_level_after", rx_level, 5'd0);
    cfg_parity = 2'd0;

    // RX overrun: 17 frames with the host stalled.
    ovr_base = ovr_cnt;
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("ovr_level", rx_level, 5'd16);
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    for (int i = 0; i < 16; i++) expect_rx($sformatf("ovr%0d", i), 8'(8'h10 + i), 1'b0, 1'b0);
    check("ovr_drained", rx_level, 5'd0);

    // TX FIFO fill with continuous valid; frames must chain without gaps.
    k = 0; n = 0; t0 = -1;
    @(negedge clk);
    while (k < 17 && n < 200) begin
      tx_valid = 1'b1;
      tx_data  = 8'(8'hC0 + k);
      if (tx_ready) k++;
      @(negedge clk);
      n++;
      if (t0 < 0 && tx == 1'b0) t0 = n;
    end
    tx_valid = 1'b0;
    check("fill_level", tx_level, 5'd16);
    check("fill_ready", tx_ready, 1'b0);
    while (tx_busy && n < 20000) begin
      @(negedge clk);
      n++;
      if (t0 < 0 && tx == 1'b0) t0 = n;
    end
    check("chain_len", n - t0, 17 * 640);
    check("chain_level", tx_level, 5'd0);
    check("chain_ready", tx_ready, 1'b1);

    // Reset in the middle of a DATA bit.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    check("pre_rst_rx_level", rx_level, 5'd1);
    push(8'h11); push(8'h22); push(8'h33);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    check("pre_rst_tx_level", tx_level, 5'd2);
    check("pre_rst_tx", tx, 8'h11 & 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", tx, 1'b1);
    check("abort_tx_level", tx_level, 5'd0);
    check("abort_rx_level", rx_level, 5'd0);
    check("abort_tx_busy", tx_busy, 1'b0);
    check("abort_rx_valid", rx_valid, 1'b0);
    rst_n = 1'b1;

    // Short low glitch must be rejected, and a real frame still received.
    repeat (10) @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_level", rx_level, 5'd0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    expect_rx("post_glitch", 8'h96, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
